flow_stepper: RTL and testbench

Run/step clock-enable controller for the flow processor core, and the parametrised successor of the fixed user-clock/clock-lock stepping logic. It gates a single clock enable into the datapath and controlpath. It supports free-run, single-step and N-instruction bursts. It adds breakpoint channels and a sticky halt on any raised error bit. It sits beside the controlpath and drives `current_state` and `switch_clock` for the board-level display.

---
 rtl/flow_pkg.sv | 15 +
 rtl/flow_bp_match.sv | 15 +
 rtl/flow_stepper.sv | 185 ++++++++++++++++++
 tb/tb_flow_stepper.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared state encoding for the flow processor stepping logic.
// The controlpath imports this package to decode current_state.
package flow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_BREAK = 3'd3,
        ST_ERROR = 3'd4
    } flow_step_state_t;

    localparam int FLOW_STEP_NUM_STATES = 5;

endpackage

// File: rtl/flow_bp_match.sv
// Single masked instruction comparator for one breakpoint channel.
// Mask bits set to 1 take part in the compare; a disabled channel never hits.
module flow_bp_match #(
    parameter int W = 16
) (
    input  logic         i_enable,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pattern,
    input  logic [W-1:0] i_mask,
    output logic         o_hit
);

    assign o_hit = i_enable && (((i_instr ^ i_pattern) & i_mask) == '0);

endmodule

// File: rtl/flow_stepper.sv
// Run/step clock-enable controller: free-run, N-instruction bursts, sticky error halt.
// Breakpoint channels are built only when FLOW_STEPPER_BREAKPOINT_EN is defined.
module flow_stepper
    import flow_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int FLAG_WIDTH  = 16,
    parameter int NUM_BP      = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          user_clock,
    input  logic                          clock_lock,
    input  logic [COUNT_WIDTH-1:0]        burst_count,
    input  logic [INSTR_WIDTH-1:0]        current_instruction,
    input  logic                          instr_done,
    input  logic [FLAG_WIDTH-1:0]         errorbit,
    input  logic [NUM_BP-1:0]             bp_enable,
    input  logic [NUM_BP*INSTR_WIDTH-1:0] bp_pattern,
    input  logic [NUM_BP*INSTR_WIDTH-1:0] bp_mask,
    output logic                          core_enable,
    output logic                          switch_clock,
    output logic [2:0]                    current_state,
    output logic [NUM_BP-1:0]             halted_bp,
    output logic [COUNT_WIDTH-1:0]        steps_remaining,
    output logic                          error_halt
);

    logic                   r_ul_s1, r_ul_s2, r_ul_s3, r_press;
    logic                   r_lk_s1, r_lk_s2, r_lk_d, r_switch;
    flow_step_state_t       r_state;
    logic                   r_core_enable;
    logic                   r_error_halt;
    logic [NUM_BP-1:0]      r_halted_bp;
    logic [COUNT_WIDTH-1:0] r_steps;

    logic                   w_lock;
    logic                   w_lock_rise;
    logic                   w_retire;
    logic                   w_error;
    logic                   w_hit;
    logic [NUM_BP-1:0]      w_hit_vec;
    logic [COUNT_WIDTH-1:0] w_load;
    logic [COUNT_WIDTH-1:0] w_steps_dec;

    // Both asynchronous buttons get two sync stages; user_clock adds a registered edge detector.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ul_s1  <= 1'b0;
            r_ul_s2  <= 1'b0;
            r_ul_s3  <= 1'b0;
            r_press  <= 1'b0;
            r_lk_s1  <= 1'b0;
            r_lk_s2  <= 1'b0;
            r_lk_d   <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_ul_s1  <= user_clock;
            r_ul_s2  <= r_ul_s1;
            r_ul_s3  <= r_ul_s2;
            r_press  <= r_ul_s2 & ~r_ul_s3;
            r_lk_s1  <= clock_lock;
            r_lk_s2  <= r_lk_s1;
            r_lk_d   <= r_lk_s2;
            r_switch <= r_lk_s2 ^ r_lk_d;
        end
    end

    assign w_lock      = r_lk_s2;
    assign w_lock_rise = r_lk_s2 & ~r_lk_d;
    assign w_retire    = instr_done & r_core_enable;
    assign w_error     = |errorbit;
    assign w_load      = (burst_count == '0) ? COUNT_WIDTH'(1) : burst_count;
    assign w_steps_dec = r_steps - COUNT_WIDTH'(1);

`ifdef FLOW_STEPPER_BREAKPOINT_EN
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
        flow_bp_match #(.W(INSTR_WIDTH)) u_bp_match (
            .i_enable  (bp_enable[gi]),
            .i_instr   (current_instruction),
            .i_pattern (bp_pattern[gi*INSTR_WIDTH +: INSTR_WIDTH]),
            .i_mask    (bp_mask[gi*INSTR_WIDTH +: INSTR_WIDTH]),
            .o_hit     (w_hit_vec[gi])
        );
    end
    assign halted_bp = r_halted_bp;
`else
    logic w_unused_bp;
    assign w_hit_vec   = '0;
    assign halted_bp   = '0;
    assign w_unused_bp = ^{bp_enable, bp_pattern, bp_mask, current_instruction, r_halted_bp};
`endif

    assign w_hit = |w_hit_vec;

    // Checks are taken only at retirement, so core_enable falls right after the final instr_done.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_core_enable <= 1'b0;
            r_error_halt  <= 1'b0;
            r_halted_bp   <= '0;
            r_steps       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lock) begin
                        r_state       <= ST_RUN;
                        r_core_enable <= 1'b1;
                        r_steps       <= '0;
                    end else if (r_press) begin
                        r_state       <= ST_STEP;
                        r_core_enable <= 1'b1;
                        r_steps       <= w_load;
                    end
                end
                ST_STEP: begin
                    if (w_retire && w_error) begin
                        r_state       <= ST_ERROR;
                        r_core_enable <= 1'b0;
                        r_error_halt  <= 1'b1;
                        r_steps       <= w_steps_dec;
                    end else if (w_retire && w_hit) begin
                        r_state       <= ST_BREAK;
                        r_core_enable <= 1'b0;
                        r_halted_bp   <= w_hit_vec;
                        r_steps       <= w_steps_dec;
                    end else if (w_lock) begin
                        r_state <= ST_RUN;
                        r_steps <= '0;
                    end else if (w_retire) begin
                        r_steps <= w_steps_dec;
                        if (r_steps == COUNT_WIDTH'(1)) begin
                            r_state       <= ST_IDLE;
                            r_core_enable <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_retire && w_error) begin
                        r_state       <= ST_ERROR;
                        r_core_enable <= 1'b0;
                        r_error_halt  <= 1'b1;
                    end else if (w_retire && w_hit) begin
                        r_state       <= ST_BREAK;
                        r_core_enable <= 1'b0;
                        r_halted_bp   <= w_hit_vec;
                    end else if (w_retire && !w_lock) begin
                        r_state       <= ST_IDLE;
                        r_core_enable <= 1'b0;
                    end
                end
                ST_BREAK: begin
                    if (r_press) begin
                        r_state       <= ST_STEP;
                        r_core_enable <= 1'b1;
                        r_steps       <= w_load;
                        r_halted_bp   <= '0;
                    end else if (w_lock_rise) begin
                        r_state       <= ST_RUN;
                        r_core_enable <= 1'b1;
                        r_steps       <= '0;
                        r_halted_bp   <= '0;
                    end
                end
                ST_ERROR: begin
                    r_core_enable <= 1'b0;
                    r_error_halt  <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_core_enable <= 1'b0;
                end
            endcase
        end
    end

    assign core_enable     = r_core_enable;
    assign switch_clock    = r_switch;
    assign current_state   = r_state;
    assign steps_remaining = r_steps;
    assign error_halt      = r_error_halt;

endmodule

// File: tb/tb_flow_stepper.sv
// Bench for flow_stepper: directed scenarios plus a randomized phase, checked each cycle
// against a cycle-level model of the stepping rules; breakpoint expectations follow FLOW_STEPPER_BREAKPOINT_EN.
module tb_flow_stepper;

    localparam int IW = 16;
    localparam int FW = 16;
    localparam int NB = 2;
    localparam int CW = 16;

    localparam int M_IDLE  = 0;
    localparam int M_STEP  = 1;
    localparam int M_RUN   = 2;
    localparam int M_BREAK = 3;
    localparam int M_ERROR = 4;

    logic           clock = 1'b0;
    logic           resetn;
    logic           user_clock;
    logic           clock_lock;
    logic [CW-1:0]  burst_count;
    logic [IW-1:0]  current_instruction;
    logic           instr_done;
    logic [FW-1:0]  errorbit;
    logic [NB-1:0]  bp_enable;
    logic [NB*IW-1:0] bp_pattern;
    logic [NB*IW-1:0] bp_mask;
    logic           core_enable;
    logic           switch_clock;
    logic [2:0]     current_state;
    logic [NB-1:0]  halted_bp;
    logic [CW-1:0]  steps_remaining;
    logic           error_halt;

    flow_stepper #(
        .INSTR_WIDTH (IW),
        .FLAG_WIDTH  (FW),
        .NUM_BP      (NB),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock               (clock),
        .resetn              (resetn),
        .user_clock          (user_clock),
        .clock_lock          (clock_lock),
        .burst_count         (burst_count),
        .current_instruction (current_instruction),
        .instr_done          (instr_done),
        .errorbit            (errorbit),
        .bp_enable           (bp_enable),
        .bp_pattern          (bp_pattern),
        .bp_mask             (bp_mask),
        .core_enable         (core_enable),
        .switch_clock        (switch_clock),
        .current_state       (current_state),
        .halted_bp           (halted_bp),
        .steps_remaining     (steps_remaining),
        .error_halt          (error_halt)
    );

    // clock / reset
    always #5 clock = ~clock;

    // reference model state
    int            m_mode;
    logic          m_ce;
    logic [CW-1:0] m_steps;
    logic [NB-1:0] m_halt;
    logic          m_sw;
    logic [4:1]    u_h;
    logic [4:1]    l_h;

    // bench bookkeeping
    int            checks = 0;
    int            failures = 0;
    int            period = 4;
    int            en_cnt = 0;
    bit            rand_period = 0;
    bit            track = 0;
    int            obs_retires = 0;
    bit            obs_last_retire = 0;
    int            sw_cnt = 0;
    logic [2:0]    obs_prev_state = 3'd0;
    logic [IW-1:0] instr_q[$];
    logic [CW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] model_hits(input logic [IW-1:0] ins);
        logic [NB-1:0] h;
        h = '0;
`ifdef FLOW_STEPPER_BREAKPOINT_EN
        for (int c = 0; c < NB; c++) begin
            logic [IW-1:0] p;
            logic [IW-1:0] m;
            p = bp_pattern[c*IW +: IW];
            m = bp_mask[c*IW +: IW];
            h[c] = bp_enable[c] && ((ins & m) == (p & m));
        end
`else
        if (ins === 'x) h = '0;
`endif
        return h;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_ce    = 1'b0;
        m_steps = '0;
        m_halt  = '0;
        m_sw    = 1'b0;
        u_h     = '0;
        l_h     = '0;
        en_cnt  = 0;
    endtask

    task automatic check_outputs();
        chk("current_state",   {29'd0, current_state}, m_mode);
        chk("core_enable",     {31'd0, core_enable}, {31'd0, m_ce});
        chk("switch_clock",    {31'd0, switch_clock}, {31'd0, m_sw});
        chk("steps_remaining", {16'd0, steps_remaining}, {16'd0, m_steps});
        chk("halted_bp",       {30'd0, halted_bp}, {30'd0, m_halt});
        chk("error_halt",      {31'd0, error_halt}, (m_mode == M_ERROR) ? 32'd1 : 32'd0);
    endtask

    // driver: one clock with model advance and full output check
    task automatic cycle();
        logic          press, lk, rise, retire, err, obs_evt, pre_ce;
        logic [NB-1:0] hits;
        logic [CW-1:0] ld;
        int            n_mode;
        logic [CW-1:0] n_steps;
        logic [NB-1:0] n_halt;

        if (m_ce) instr_done = (en_cnt >= period - 1);
        else      instr_done = ($urandom_range(0, 3) == 0);

        pre_ce  = m_ce;
        retire  = instr_done && m_ce;
        obs_evt = instr_done && core_enable;
        press   = u_h[3] & ~u_h[4];
        lk      = l_h[2];
        rise    = l_h[2] & ~l_h[3];
        err     = (errorbit != '0);
        hits    = model_hits(current_instruction);
        ld      = (burst_count == '0) ? CW'(1) : burst_count;
        n_mode  = m_mode;
        n_steps = m_steps;
        n_halt  = m_halt;

        case (m_mode)
            M_IDLE: begin
                if (lk)         begin n_mode = M_RUN; n_steps = '0; end
                else if (press) begin n_mode = M_STEP; n_steps = ld; end
            end
            M_STEP: begin
                if (retire && err)          begin n_mode = M_ERROR; n_steps = m_steps - 1'b1; end
                else if (retire && hits != 0) begin n_mode = M_BREAK; n_halt = hits; n_steps = m_steps - 1'b1; end
                else if (lk)                begin n_mode = M_RUN; n_steps = '0; end
                else if (retire) begin
                    n_steps = m_steps - 1'b1;
                    if (m_steps == 1) n_mode = M_IDLE;
                end
            end
            M_RUN: begin
                if (retire && err)            n_mode = M_ERROR;
                else if (retire && hits != 0) begin n_mode = M_BREAK; n_halt = hits; end
                else if (retire && !lk)       n_mode = M_IDLE;
            end
            M_BREAK: begin
                if (press)     begin n_mode = M_STEP; n_steps = ld; n_halt = '0; end
                else if (rise) begin n_mode = M_RUN; n_steps = '0; n_halt = '0; end
            end
            default: ;
        endcase

        @(posedge clock);
        #1;
        if (resetn) begin
            m_sw    = l_h[2] ^ l_h[3];
            u_h     = {u_h[3:1], user_clock};
            l_h     = {l_h[3:1], clock_lock};
            m_mode  = n_mode;
            m_steps = n_steps;
            m_halt  = n_halt;
            m_ce    = (n_mode == M_STEP) || (n_mode == M_RUN);
            if (retire) begin
                en_cnt = 0;
                current_instruction = (instr_q.size() > 0) ? instr_q.pop_front() : IW'($urandom);
                if (rand_period) period = $urandom_range(1, 5);
            end else if (pre_ce) begin
                en_cnt++;
            end else begin
                en_cnt = 0;
            end
        end else begin
            model_reset();
        end

        obs_last_retire = obs_evt;
        if (obs_evt) begin
            obs_retires++;
            if (track && exp_q.size() > 0) chk("burst_steps", {16'd0, steps_remaining}, {16'd0, exp_q.pop_front()});
            if (track && obs_retires == 3) chk("ce_after_last", {31'd0, core_enable}, 32'd0);
        end
        if (track && current_state == 3'd1 && obs_prev_state == 3'd0 && exp_q.size() > 0)
            chk("burst_load", {16'd0, steps_remaining}, {16'd0, exp_q.pop_front()});
        if (switch_clock) sw_cnt++;
        obs_prev_state = current_state;
        check_outputs();
    endtask

    task automatic press_button(input int hold);
        user_clock = 1'b1;
        repeat (hold) cycle();
        user_clock = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) cycle();
        resetn = 1'b1;
    endtask

    initial begin
        int k;
        resetn = 1'b0;
        user_clock = 1'b0;
        clock_lock = 1'b0;
        burst_count = CW'(1);
        current_instruction = 16'h0101;
        instr_done = 1'b0;
        errorbit = '0;
        bp_enable = '0;
        bp_pattern = '0;
        bp_mask = '0;
        model_reset();
        repeat (3) cycle();
        resetn = 1'b1;
        repeat (2) cycle();
        chk("reset_state", {29'd0, current_state}, 32'd0);

        // reset in the middle of free-run
        clock_lock = 1'b1;
        repeat (10) cycle();
        chk("run_entered", {29'd0, current_state}, 32'd2);
        clock_lock = 1'b0;
        apply_reset();
        chk("rst_mid_run_state", {29'd0, current_state}, 32'd0);
        chk("rst_mid_run_ce", {31'd0, core_enable}, 32'd0);
        repeat (4) cycle();

        // burst of three, instr_done every 4 enabled cycles
        burst_count = CW'(3);
        period = 4;
        exp_q = '{CW'(3), CW'(2), CW'(1), CW'(0)};
        track = 1;
        obs_retires = 0;
        press_button(3);
        repeat (40) cycle();
        track = 0;
        chk("burst3_retires", obs_retires, 32'd3);
        chk("burst3_idle", {29'd0, current_state}, 32'd0);
        chk("burst3_queue_drained", exp_q.size(), 32'd0);

        // zero burst behaves as one
        burst_count = '0;
        obs_retires = 0;
        press_button(2);
        repeat (30) cycle();
        chk("burst0_retires", obs_retires, 32'd1);

        // lock dropped mid-instruction
        period = 8;
        clock_lock = 1'b1;
        k = 0;
        do begin cycle(); k++; end while (!(m_mode == M_RUN && en_cnt == 1) && k < 60);
        clock_lock = 1'b0;
        sw_cnt = 0;
        k = 0;
        do begin cycle(); k++; end while (current_state == 3'd2 && k < 40);
        chk("drop_wait_cycles", k, 32'd7);
        chk("drop_last_done", {31'd0, obs_last_retire}, 32'd1);
        chk("drop_idle", {29'd0, current_state}, 32'd0);
        repeat (5) cycle();
        chk("drop_switch_pulses", sw_cnt, 32'd1);

        // breakpoint on channel 1
        period = 3;
        bp_enable = 2'b10;
        bp_pattern = {16'hA000, 16'h0000};
        bp_mask = {16'hF000, 16'h0000};
        current_instruction = 16'h0101;
        instr_q = '{16'h1111, 16'h2222, 16'hA3C5, 16'h1234};
`ifdef FLOW_STEPPER_BREAKPOINT_EN
        clock_lock = 1'b1;
        k = 0;
        do begin cycle(); k++; end while (current_state != 3'd3 && k < 60);
        chk("bp_state", {29'd0, current_state}, 32'd3);
        chk("bp_halted", {30'd0, halted_bp}, 32'd2);
        chk("bp_ce", {31'd0, core_enable}, 32'd0);
        clock_lock = 1'b0;
        repeat (6) cycle();
        chk("bp_holds", {29'd0, current_state}, 32'd3);
        burst_count = CW'(1);
        obs_retires = 0;
        press_button(3);
        repeat (20) cycle();
        chk("bp_resume_retires", obs_retires, 32'd1);
        chk("bp_resume_idle", {29'd0, current_state}, 32'd0);
        chk("bp_halted_cleared", {30'd0, halted_bp}, 32'd0);
`else
        clock_lock = 1'b1;
        repeat (30) cycle();
        chk("nobp_still_run", {29'd0, current_state}, 32'd2);
        chk("nobp_halted_zero", {30'd0, halted_bp}, 32'd0);
        clock_lock = 1'b0;
        repeat (20) cycle();
        chk("nobp_idle", {29'd0, current_state}, 32'd0);
`endif

        // randomized phase
        rand_period = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    burst_count = CW'($urandom_range(0, 4));
                    press_button($urandom_range(2, 4));
                end
                1: clock_lock = ~clock_lock;
                2: begin
                    bp_enable = NB'($urandom);
                    bp_pattern = {IW'($urandom), IW'($urandom)};
                    bp_mask = {IW'($urandom) & 16'h0007, IW'($urandom) & 16'h0007};
                end
                default: ;
            endcase
            repeat ($urandom_range(3, 12)) cycle();
        end
        clock_lock = 1'b0;
        repeat (30) cycle();
        rand_period = 0;
        period = 3;

        // error at a retirement that also matches a breakpoint
        apply_reset();
        instr_q.delete();
        bp_enable = 2'b10;
        bp_pattern = {16'hA000, 16'h0000};
        bp_mask = {16'hF000, 16'h0000};
        current_instruction = 16'hA3C5;
        errorbit = 16'h0040;
        clock_lock = 1'b1;
        k = 0;
        do begin cycle(); k++; end while (current_state != 3'd4 && k < 40);
        chk("err_state", {29'd0, current_state}, 32'd4);
        chk("err_halt", {31'd0, error_halt}, 32'd1);
        chk("err_halted_bp", {30'd0, halted_bp}, 32'd0);
        press_button(3);
        clock_lock = 1'b0;
        repeat (6) cycle();
        clock_lock = 1'b1;
        repeat (6) cycle();
        press_button(3);
        repeat (6) cycle();
        chk("err_sticky_state", {29'd0, current_state}, 32'd4);
        chk("err_sticky_ce", {31'd0, core_enable}, 32'd0);
        errorbit = '0;
        clock_lock = 1'b0;
        apply_reset();
        repeat (2) cycle();
        chk("final_reset_state", {29'd0, current_state}, 32'd0);
        chk("final_reset_halt", {31'd0, error_halt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
